writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter: CNT_W, 32, width of the retired-instruction counter.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  upstream (MEM) presents an instruction.
REQ-005 in_ready  out  1  stage can accept an instruction this cycle.
REQ-006 in_rd  in  5  destination register index.
REQ-007 in_reg_write  in  1  instruction writes a register.
REQ-008 in_wb_sel  in  2  source select: 00 ALU, 01 LOAD, 10 PC+4, 11 reserved.
REQ-009 in_alu_result  in  32  ALU result.
REQ-010 in_pc4  in  32  PC+4 (link value).
REQ-011 in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-012 in_addr_lo  in  2  low bits of the load address.
REQ-013 dmem_rvalid  in  1  load data valid this cycle.
REQ-014 dmem_rdata  in  32  raw aligned load word.
REQ-015 rf_we  out  1  register-file write enable (drives regfile we).
REQ-016 rf_wa  out  5  register-file write address (drives regfile wa).
REQ-017 rf_wd  out  32  register-file write data (drives regfile wd).
REQ-018 err  out  1  one-cycle pulse on a protocol or encoding error.
REQ-019 retired  out  CNT_W  count of instructions completed.

Function
REQ-020 The FSM SHALL have the states IDLE and WAIT_LOAD; in_ready SHALL be 1 only in IDLE.
REQ-021 An instruction SHALL be accepted when in_valid && in_ready.
REQ-022 Accept in IDLE with wb_sel 00 or 10 -> rf_we/rf_wa/rf_wd SHALL be registered and valid on the next cycle (latency 1); the FSM SHALL stay in IDLE.
REQ-023 rf_wd SHALL be in_alu_result for wb_sel 00 and in_pc4 for wb_sel 10.
REQ-024 Accept with wb_sel 01 -> the stage SHALL latch rd, reg_write, funct3 and addr_lo, then move to WAIT_LOAD.
REQ-025 In WAIT_LOAD with dmem_rvalid=1 -> extracted data SHALL appear on rf_wd with rf_we on the next cycle, and the FSM SHALL return to IDLE.
REQ-026 In WAIT_LOAD the stage SHALL accept no new instruction until the load completes; there is no timeout.
REQ-027 Byte extraction SHALL use byte dmem_rdata[8*addr_lo +: 8]; LB sign-extends, LBU zero-extends.
REQ-028 Halfword extraction SHALL use addr_lo[1] to select the upper or lower half, ignoring addr_lo[0]; LH sign-extends, LHU zero-extends.
REQ-029 LW SHALL pass dmem_rdata unchanged and ignore addr_lo.
REQ-030 Any other funct3 on a load SHALL suppress rf_we, pulse err on the completion cycle, and still count the instruction as retired.
REQ-031 wb_sel 11 on accept SHALL suppress rf_we, pulse err the next cycle, and count the instruction as retired.
REQ-032 rf_we SHALL be 0 whenever reg_write=0 or rd=0; the write to x0 SHALL be suppressed in this stage.
REQ-033 rf_we SHALL be asserted for exactly one cycle per completed writing instruction, and SHALL be 0 on all other cycles.
REQ-034 dmem_rvalid in IDLE SHALL be ignored for data and SHALL pulse err on the next cycle.
REQ-035 A simultaneous accept and unexpected dmem_rvalid in IDLE SHALL process the accept normally and also pulse err.
REQ-036 retired SHALL increment by 1 on each completion cycle (non-load accept, or load data receipt), including suppressed writes.
REQ-037 retired SHALL wrap from 2^CNT_W-1 to 0 without error.

Reset
REQ-038 While rst=1 at a clock edge, the stage SHALL go to IDLE, set rf_we=0, rf_wa=0, rf_wd=0, err=0 and retired=0.
REQ-039 in_ready SHALL be 1 on the cycle after reset is released.
REQ-040 Reset during WAIT_LOAD SHALL discard the pending load; a dmem_rvalid arriving after reset SHALL be treated as unexpected (REQ-034).
REQ-041 Inputs SHALL be ignored while rst=1.

Verification
REQ-042 ALU path: accept wb_sel=00, rd=5, alu=0x1111_2222 -> next cycle rf_we=1, rf_wa=5, rf_wd=0x1111_2222, retired=1.
REQ-043 LB: rd=7, addr_lo=3, rdata=0x80FF_0000 arriving 3 cycles later -> in_ready=0 during the wait, then rf_wd=0xFFFF_FF80; LBU gives 0x0000_0080.
REQ-044 LH: addr_lo=2, rdata=0x8001_1234 -> rf_wd=0xFFFF_8001; LHU gives 0x0000_8001; LW gives 0x8001_1234.
REQ-045 x0 suppression: JAL with wb_sel=10, rd=0, pc4=0x0000_0104 -> rf_we stays 0 and retired increments.
REQ-046 Errors: dmem_rvalid in IDLE -> err pulse with rf_we=0; rst asserted mid-WAIT_LOAD, then rvalid -> no write and err=1.
REQ-047 Wrap: CNT_W=4, 16 back-to-back ALU accepts -> retired returns to 0, with one rf_we pulse per cycle and in_ready held at 1.

Source files
------------

// File: rtl/writeback_stage.sv
// Purpose: writeback stage; selects ALU/load/link data, drives the regfile write port, counts retirements.
// Latency: 1 cycle from accept (ALU/PC+4) or from dmem_rvalid (load) to rf_we/rf_wa/rf_wd.
// Backpressure: in_ready drops while a load is outstanding; no new accept until dmem_rvalid returns.
module writeback_stage #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_rd,
   input  logic             in_reg_write,
   input  logic [1:0]       in_wb_sel,
   input  logic [31:0]      in_alu_result,
   input  logic [31:0]      in_pc4,
   input  logic [2:0]       in_funct3,
   input  logic [1:0]       in_addr_lo,
   input  logic             dmem_rvalid,
   input  logic [31:0]      dmem_rdata,
   output logic             rf_we,
   output logic [4:0]       rf_wa,
   output logic [31:0]      rf_wd,
   output logic             err,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_LOAD = 1'b1
   } state_t;

   localparam logic [1:0] SEL_ALU  = 2'b00;
   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_PC4  = 2'b10;

   state_t      state;
   logic [4:0]  l_rd;
   logic        l_reg_write;
   logic [2:0]  l_funct3;
   logic [1:0]  l_addr_lo;

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic        ld_ok;

   // The stage only takes new work when no load is outstanding.
   assign in_ready = (state == IDLE);

   // Load data extraction from the latched load type and address offset.
   always_comb begin
      ld_byte = 8'h00;
      ld_data = 32'h0000_0000;
      ld_ok   = 1'b1;
      case (l_addr_lo)
         2'd0:    ld_byte = dmem_rdata[7:0];
         2'd1:    ld_byte = dmem_rdata[15:8];
         2'd2:    ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      // Halfword select ignores addr_lo[0]; misaligned halves are not split.
      ld_half = l_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (l_funct3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b010:  ld_data = dmem_rdata;
         3'b100:  ld_data = {24'h000000, ld_byte};
         3'b101:  ld_data = {16'h0000, ld_half};
         default: ld_ok   = 1'b0;
      endcase
   end

   // FSM, registered regfile write port, error pulse and retirement counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rf_we       <= 1'b0;
         rf_wa       <= 5'd0;
         rf_wd       <= 32'h0000_0000;
         err         <= 1'b0;
         retired     <= '0;
         l_rd        <= 5'd0;
         l_reg_write <= 1'b0;
         l_funct3    <= 3'b000;
         l_addr_lo   <= 2'b00;
      end else begin
         rf_we <= 1'b0;
         err   <= 1'b0;
         case (state)
            IDLE: begin
               // Read data with no load outstanding is dropped but flagged.
               if (dmem_rvalid) begin
                  err <= 1'b1;
               end
               if (in_valid) begin
                  case (in_wb_sel)
                     SEL_ALU: begin
                        rf_we   <= in_reg_write && (in_rd != 5'd0);
                        rf_wa   <= in_rd;
                        rf_wd   <= in_alu_result;
                        retired <= retired + CNT_W'(1);
                     end
                     SEL_PC4: begin
                        rf_we   <= in_reg_write && (in_rd != 5'd0);
                        rf_wa   <= in_rd;
                        rf_wd   <= in_pc4;
                        retired <= retired + CNT_W'(1);
                     end
                     SEL_LOAD: begin
                        l_rd        <= in_rd;
                        l_reg_write <= in_reg_write;
                        l_funct3    <= in_funct3;
                        l_addr_lo   <= in_addr_lo;
                        state       <= WAIT_LOAD;
                     end
                     default: begin
                        // Reserved select still retires so the count stays consistent.
                        err     <= 1'b1;
                        retired <= retired + CNT_W'(1);
                     end
                  endcase
               end
            end
            WAIT_LOAD: begin
               // No timeout: the stage waits indefinitely for the load data.
               if (dmem_rvalid) begin
                  if (ld_ok) begin
                     rf_we <= l_reg_write && (l_rd != 5'd0);
                     rf_wa <= l_rd;
                     rf_wd <= ld_data;
                  end else begin
                     err <= 1'b1;
                  end
                  retired <= retired + CNT_W'(1);
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Purpose: directed bench for writeback_stage with an expected-output queue.
// Latency: each step drives one cycle of inputs and checks the outputs one cycle later.
// Backpressure: in_valid is held high during load waits to confirm nothing is accepted.
module tb_writeback_stage;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       in_rd;
   logic             in_reg_write;
   logic [1:0]       in_wb_sel;
   logic [31:0]      in_alu_result;
   logic [31:0]      in_pc4;
   logic [2:0]       in_funct3;
   logic [1:0]       in_addr_lo;
   logic             dmem_rvalid;
   logic [31:0]      dmem_rdata;
   logic             rf_we;
   logic [4:0]       rf_wa;
   logic [31:0]      rf_wd;
   logic             err;
   logic [CNT_W-1:0] retired;

   typedef struct {
      logic             we;
      logic [4:0]       wa;
      logic [31:0]      wd;
      logic             er;
      logic [CNT_W-1:0] ret;
      logic             rdy;
      logic             full;
   } exp_t;

   exp_t             sb[$];
   int               checks = 0;
   int               errors = 0;
   logic [CNT_W-1:0] exp_ret = '0;

   always #5 clk = ~clk;

   writeback_stage #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_rd         (in_rd),
      .in_reg_write  (in_reg_write),
      .in_wb_sel     (in_wb_sel),
      .in_alu_result (in_alu_result),
      .in_pc4        (in_pc4),
      .in_funct3     (in_funct3),
      .in_addr_lo    (in_addr_lo),
      .dmem_rvalid   (dmem_rvalid),
      .dmem_rdata    (dmem_rdata),
      .rf_we         (rf_we),
      .rf_wa         (rf_wa),
      .rf_wd         (rf_wd),
      .err           (err),
      .retired       (retired)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] sel, input logic [4:0] rd,
                        input logic rw, input logic [31:0] alu, input logic [31:0] pc4,
                        input logic [2:0] f3, input logic [1:0] alo,
                        input logic rv, input logic [31:0] rdata);
      in_valid      = v;
      in_wb_sel     = sel;
      in_rd         = rd;
      in_reg_write  = rw;
      in_alu_result = alu;
      in_pc4        = pc4;
      in_funct3     = f3;
      in_addr_lo    = alo;
      dmem_rvalid   = rv;
      dmem_rdata    = rdata;
   endtask

   task automatic drive_idle();
      drive(1'b0, 2'b00, 5'd0, 1'b0, 32'h0, 32'h0, 3'b000, 2'b00, 1'b0, 32'h0);
   endtask

   // Push the expected outputs for the cycle after the current inputs, then advance and compare.
   task automatic exp_cycle(input string tag, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd, input logic er, input logic rdy,
                            input logic full);
      exp_t e;
      e.we = we; e.wa = wa; e.wd = wd; e.er = er; e.ret = exp_ret; e.rdy = rdy; e.full = full;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, ".rf_we"}, 32'(rf_we), 32'(e.we));
      chk({tag, ".err"}, 32'(err), 32'(e.er));
      chk({tag, ".retired"}, 32'(retired), 32'(e.ret));
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(e.rdy));
      if (e.we || e.full) begin
         chk({tag, ".rf_wa"}, 32'(rf_wa), 32'(e.wa));
         chk({tag, ".rf_wd"}, rf_wd, e.wd);
      end
   endtask

   // Accept a load, wait nwait cycles with a competing in_valid, then return the data.
   task automatic do_load(input string tag, input logic [4:0] rd, input logic rw,
                          input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] rdata,
                          input int nwait, input logic we, input logic [31:0] wd, input logic er);
      drive(1'b1, 2'b01, rd, rw, 32'hDEAD_BEEF, 32'hCAFE_0000, f3, alo, 1'b0, 32'h0);
      exp_cycle({tag, ".acc"}, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < nwait; i++) begin
         drive(1'b1, 2'b00, 5'd9, 1'b1, 32'h5555_AAAA, 32'h0, 3'b000, 2'b00, 1'b0, 32'h0);
         exp_cycle({tag, ".wait"}, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
      end
      drive(1'b0, 2'b00, 5'd0, 1'b0, 32'h0, 32'h0, 3'b000, 2'b00, 1'b1, rdata);
      exp_ret++;
      exp_cycle({tag, ".data"}, we, rd, wd, er, 1'b1, 1'b0);
      drive_idle();
   endtask

   initial begin
      // Reset with junk on every input, including a load accept and stray rvalid.
      rst = 1'b1;
      drive(1'b1, 2'b01, 5'd5, 1'b1, 32'h1234_5678, 32'h4, 3'b000, 2'b11, 1'b1, 32'hFFFF_FFFF);
      exp_cycle("reset0", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1);
      exp_cycle("reset1", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1);
      rst = 1'b0;
      drive_idle();
      exp_cycle("post_reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1);

      // ALU writeback, then rf_we must drop.
      drive(1'b1, 2'b00, 5'd5, 1'b1, 32'h1111_2222, 32'h0, 3'b000, 2'b00, 1'b0, 32'h0);
      exp_ret++;
      exp_cycle("alu", 1'b1, 5'd5, 32'h1111_2222, 1'b0, 1'b1, 1'b0);
      drive_idle();
      exp_cycle("alu_drop", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);

      // Load extraction cases.
      do_load("lb",     5'd7,  1'b1, 3'b000, 2'd3, 32'h80FF_0000, 2, 1'b1, 32'hFFFF_FF80, 1'b0);
      do_load("lbu",    5'd7,  1'b1, 3'b100, 2'd3, 32'h80FF_0000, 1, 1'b1, 32'h0000_0080, 1'b0);
      do_load("lb_a1",  5'd8,  1'b1, 3'b000, 2'd1, 32'h8001_1234, 0, 1'b1, 32'h0000_0012, 1'b0);
      do_load("lbu_a2", 5'd8,  1'b1, 3'b100, 2'd2, 32'h8001_1234, 0, 1'b1, 32'h0000_0001, 1'b0);
      do_load("lh",     5'd10, 1'b1, 3'b001, 2'd2, 32'h8001_1234, 1, 1'b1, 32'hFFFF_8001, 1'b0);
      do_load("lhu",    5'd11, 1'b1, 3'b101, 2'd2, 32'h8001_1234, 1, 1'b1, 32'h0000_8001, 1'b0);
      do_load("lh_a3",  5'd12, 1'b1, 3'b001, 2'd3, 32'h8001_1234, 0, 1'b1, 32'hFFFF_8001, 1'b0);
      do_load("lh_a1",  5'd12, 1'b1, 3'b001, 2'd1, 32'h8001_9234, 0, 1'b1, 32'hFFFF_9234, 1'b0);
      do_load("lw",     5'd13, 1'b1, 3'b010, 2'd2, 32'h8001_1234, 1, 1'b1, 32'h8001_1234, 1'b0);
      do_load("bad_f3", 5'd14, 1'b1, 3'b011, 2'd0, 32'h8001_1234, 0, 1'b0, 32'h0, 1'b1);
      do_load("ld_x0",  5'd0,  1'b1, 3'b010, 2'd0, 32'h8001_1234, 0, 1'b0, 32'h0, 1'b0);
      do_load("ld_nowr",5'd3,  1'b0, 3'b010, 2'd0, 32'h8001_1234, 0, 1'b0, 32'h0, 1'b0);

      // JAL link write to x0 is suppressed but retires; to x1 it writes.
      drive(1'b1, 2'b10, 5'd0, 1'b1, 32'hAAAA_0000, 32'h0000_0104, 3'b000, 2'b00, 1'b0, 32'h0);
      exp_ret++;
      exp_cycle("jal_x0", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 2'b10, 5'd1, 1'b1, 32'hAAAA_0000, 32'h0000_0104, 3'b000, 2'b00, 1'b0, 32'h0);
      exp_ret++;
      exp_cycle("jal_x1", 1'b1, 5'd1, 32'h0000_0104, 1'b0, 1'b1, 1'b0);

      // Reserved select: error, no write, retires.
      drive(1'b1, 2'b11, 5'd4, 1'b1, 32'h1, 32'h2, 3'b000, 2'b00, 1'b0, 32'h0);
      exp_ret++;
      exp_cycle("sel11", 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0);

      // ALU with reg_write clear retires without a write.
      drive(1'b1, 2'b00, 5'd5, 1'b0, 32'h7777_7777, 32'h0, 3'b000, 2'b00, 1'b0, 32'h0);
      exp_ret++;
      exp_cycle("alu_nowr", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);

      // Stray rvalid in IDLE: error only.
      drive(1'b0, 2'b00, 5'd0, 1'b0, 32'h0, 32'h0, 3'b000, 2'b00, 1'b1, 32'h1234_5678);
      exp_cycle("stray_rv", 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0);

      // Accept together with stray rvalid: normal write plus error.
      drive(1'b1, 2'b00, 5'd6, 1'b1, 32'h0BAD_F00D, 32'h0, 3'b000, 2'b00, 1'b1, 32'h9999_9999);
      exp_ret++;
      exp_cycle("acc_rv", 1'b1, 5'd6, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b0);

      // Reset while a load is pending; the later rvalid is unexpected.
      drive(1'b1, 2'b01, 5'd7, 1'b1, 32'h0, 32'h0, 3'b010, 2'b00, 1'b0, 32'h0);
      exp_cycle("rstwait.acc", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      drive(1'b1, 2'b00, 5'd9, 1'b1, 32'h1, 32'h0, 3'b000, 2'b00, 1'b1, 32'hAAAA_5555);
      exp_ret = '0;
      exp_cycle("rstwait.rst", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1);
      rst = 1'b0;
      drive(1'b0, 2'b00, 5'd0, 1'b0, 32'h0, 32'h0, 3'b000, 2'b00, 1'b1, 32'hAAAA_5555);
      exp_cycle("rstwait.rv", 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0);

      // Sixteen back-to-back ALU writes wrap the 4-bit counter to 0.
      for (int i = 0; i < 16; i++) begin
         logic [4:0]  rd_i;
         logic [31:0] wd_i;
         rd_i = 5'((i % 31) + 1);
         wd_i = 32'h0101_0101 * 32'(i + 1);
         drive(1'b1, 2'b00, rd_i, 1'b1, wd_i, 32'h0, 3'b000, 2'b00, 1'b0, 32'h0);
         exp_ret++;
         exp_cycle("wrap", 1'b1, rd_i, wd_i, 1'b0, 1'b1, 1'b0);
      end
      chk("wrap_zero", 32'(retired), 32'h0);
      drive_idle();
      exp_cycle("final", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
